// File: rtl/lo_edge_timer.sv
// lo_edge_timer: timestamps field-state transitions from the LF hysteresis
// stage and streams {level, count} interval words to the ARM over SSP.
module lo_edge_timer #(
   parameter int CNT_W      = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       pck0,
   input  logic       nreset,
   input  logic       enable,
   input  logic       field_in,
   input  logic [7:0] divisor,
   output logic       ssp_clk,
   output logic       ssp_frame,
   output logic       ssp_din,
   output logic       overflow,
   output logic       debug
);

   localparam int WW = CNT_W + 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(WW);
   localparam logic [BW-1:0]    LAST    = BW'(WW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [AW:0]      DEPTH_V = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   logic r_sync1;
   logic r_field_s;
   logic r_field_d;
   logic w_edge;

   logic [7:0] r_pre;
   logic       w_tick;

   logic [CNT_W-1:0] r_cnt;
   logic             r_armed;
   logic             w_push;
   logic [WW-1:0]    w_word;

   logic [WW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_fill;
   logic          w_full;
   logic          w_empty;
   logic          w_wr;
   logic          w_pop;
   logic [WW-1:0] w_head;
   logic          r_ovf;

   state_t        r_state;
   state_t        w_state_nx;
   logic [1:0]    r_phase;
   logic          w_ph0;
   logic [WW-1:0] r_shift;
   logic [WW-1:0] w_shift_nx;
   logic [BW-1:0] r_bitcnt;
   logic [BW-1:0] w_bitcnt_nx;
   logic          r_frame;
   logic          w_frame_nx;
   logic          r_din;
   logic          w_din_nx;

   // Two-flop synchroniser plus one delay stage for edge detection.
   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         r_sync1   <= 1'b0;
         r_field_s <= 1'b0;
         r_field_d <= 1'b0;
      end else begin
         r_sync1   <= field_in;
         r_field_s <= r_sync1;
         r_field_d <= r_field_s;
      end
   end

   assign w_edge = r_field_s ^ r_field_d;
   assign debug  = r_field_s;

   assign w_tick = enable && (r_pre == divisor);

   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         r_pre <= 8'd0;
      end else if (!enable || w_tick) begin
         r_pre <= 8'd0;
      end else begin
         r_pre <= r_pre + 8'd1;
      end
   end

   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         r_cnt <= '0;
      end else if (!enable || w_edge) begin
         r_cnt <= '0;
      end else if (w_tick && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // The interval before the first edge has no known start, so it only arms.
   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         r_armed <= 1'b0;
      end else if (!enable) begin
         r_armed <= 1'b0;
      end else if (w_edge) begin
         r_armed <= 1'b1;
      end
   end

   assign w_push  = enable && w_edge && r_armed;
   assign w_word  = {r_field_d, r_cnt};
   assign w_full  = (r_fill == DEPTH_V);
   assign w_empty = (r_fill == '0);
   assign w_wr    = w_push && (!w_full || w_pop);
   assign w_head  = r_mem[r_rp];

   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr) begin
         r_mem[r_wp] <= w_word;
      end
   end

   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_fill <= '0;
      end else if (!enable) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_fill <= '0;
      end else begin
         if (w_wr) begin
            r_wp <= r_wp + AW'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + AW'(1);
         end
         if (w_wr && !w_pop) begin
            r_fill <= r_fill + (AW + 1)'(1);
         end else if (!w_wr && w_pop) begin
            r_fill <= r_fill - (AW + 1)'(1);
         end
      end
   end

   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         r_ovf <= 1'b0;
      end else if (!enable) begin
         r_ovf <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         r_phase <= 2'd0;
      end else if (!enable) begin
         r_phase <= 2'd0;
      end else begin
         r_phase <= r_phase + 2'd1;
      end
   end

   assign w_ph0 = (r_phase == 2'd0);

   always_ff @(posedge pck0 or negedge nreset) begin
      if (!nreset) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_frame  <= 1'b0;
         r_din    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_shift  <= w_shift_nx;
         r_bitcnt <= w_bitcnt_nx;
         r_frame  <= w_frame_nx;
         r_din    <= w_din_nx;
      end
   end

   // Serial outputs only move at phase 0; the ARM samples at phase 1->2.
   always_comb begin
      w_state_nx  = r_state;
      w_shift_nx  = r_shift;
      w_bitcnt_nx = r_bitcnt;
      w_frame_nx  = r_frame;
      w_din_nx    = r_din;
      w_pop       = 1'b0;
      if (!enable) begin
         w_state_nx  = S_IDLE;
         w_shift_nx  = '0;
         w_bitcnt_nx = '0;
         w_frame_nx  = 1'b0;
         w_din_nx    = 1'b0;
      end else if (w_ph0) begin
         unique case (1'b1)
            (r_state == S_IDLE): begin
               w_frame_nx = 1'b0;
               w_din_nx   = 1'b0;
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nx  = w_head;
                  w_din_nx    = w_head[WW-1];
                  w_frame_nx  = 1'b1;
                  w_bitcnt_nx = LAST;
                  w_state_nx  = S_SHIFT;
               end
            end
            (r_state == S_SHIFT): begin
               w_frame_nx = 1'b0;
               if (r_bitcnt != '0) begin
                  w_shift_nx  = {r_shift[WW-2:0], 1'b0};
                  w_din_nx    = r_shift[WW-2];
                  w_bitcnt_nx = r_bitcnt - BW'(1);
               end else if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nx  = w_head;
                  w_din_nx    = w_head[WW-1];
                  w_frame_nx  = 1'b1;
                  w_bitcnt_nx = LAST;
               end else begin
                  w_din_nx   = 1'b0;
                  w_state_nx = S_IDLE;
               end
            end
            default: begin
               w_state_nx = S_IDLE;
            end
         endcase
      end
   end

   assign ssp_clk   = r_phase[1];
   assign ssp_frame = r_frame;
   assign ssp_din   = r_din;
   assign overflow  = r_ovf;

endmodule
